// File: rtl/commit_retire.sv
// Reorder-buffer commit/retire tracker: allocates entries in order, records writeback
// completion per entry, retires up to COMMIT_WIDTH in-order entries per cycle and flushes on exceptions.
module commit_retire #(
  parameter int ROB_DEPTH    = 16,
  parameter int ROB_ID_WIDTH = 4,
  parameter int WB_WIDTH     = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       alloc_num,
  output logic                             alloc_ready,
  output logic [ROB_ID_WIDTH-1:0]          alloc_rob_id,
  input  logic                             wb_commit_port_we,
  input  logic                             wb_commit_port_flush,
  input  logic [WB_WIDTH-1:0]              wb_valid,
  input  logic [WB_WIDTH*ROB_ID_WIDTH-1:0] wb_rob_id,
  input  logic [WB_WIDTH-1:0]              wb_has_exception,
  output logic                             commit_feedback_enable,
  output logic                             commit_feedback_flush,
  output logic [1:0]                       commit_num,
  output logic [ROB_ID_WIDTH-1:0]          commit_rob_id,
  output logic                             rob_empty
);
  localparam int CW = ROB_ID_WIDTH + 1;

  typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [ROB_ID_WIDTH-1:0] head_reg, head_next;
  logic [ROB_ID_WIDTH-1:0] tail_reg, tail_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [ROB_DEPTH-1:0]    finished_reg, finished_next;
  logic [ROB_DEPTH-1:0]    exception_reg, exception_next;
  logic [ROB_DEPTH-1:0]    occupied;
  logic [ROB_DEPTH-1:0]    alloc_hit;
  logic [1:0]              alloc_cnt;
  logic                    alloc_fire;
  logic                    wb_enable;
  logic [CW-1:0]           retire_cnt;
  logic                    retire_stop;
  logic [ROB_ID_WIDTH-1:0] retire_idx;
  logic                    exc_at_head;
  logic                    enable_next;
  logic                    flush_next;
  logic [1:0]              num_next;

  assign alloc_ready  = (state_reg == NORMAL) && (count_reg <= CW'(ROB_DEPTH - 2));
  assign alloc_rob_id = tail_reg;
  assign rob_empty    = (count_reg == '0);
  assign alloc_cnt    = (alloc_num > 2'd2) ? 2'd2 : alloc_num;
  assign alloc_fire   = alloc_ready && (alloc_cnt != 2'd0);
  assign wb_enable    = wb_commit_port_we && !wb_commit_port_flush && (state_reg == NORMAL);

  // Per-entry occupancy, allocation clear and writeback merge; allocation only touches free slots.
  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      logic [ROB_ID_WIDTH-1:0] head_off;
      logic [ROB_ID_WIDTH-1:0] tail_off;
      logic                    hit;
      logic                    exc;

      assign head_off      = ROB_ID_WIDTH'(gi) - head_reg;
      assign tail_off      = ROB_ID_WIDTH'(gi) - tail_reg;
      assign occupied[gi]  = ({1'b0, head_off} < count_reg);
      assign alloc_hit[gi] = alloc_fire && (tail_off < ROB_ID_WIDTH'(alloc_cnt));

      always_comb begin
        hit = 1'b0;
        exc = 1'b0;
        for (int c = 0; c < WB_WIDTH; c++) begin
          if (wb_enable && wb_valid[c] && occupied[gi] &&
              (wb_rob_id[c*ROB_ID_WIDTH +: ROB_ID_WIDTH] == ROB_ID_WIDTH'(gi))) begin
            hit = 1'b1;
            exc = wb_has_exception[c];
          end
        end
      end

      assign finished_next[gi]  = ((state_reg == FLUSH) || alloc_hit[gi]) ? 1'b0 :
                                  (hit ? 1'b1 : finished_reg[gi]);
      assign exception_next[gi] = ((state_reg == FLUSH) || alloc_hit[gi]) ? 1'b0 :
                                  (hit ? exc : exception_reg[gi]);
    end
  endgenerate

  // Count the in-order run of clean finished entries from head.
  always_comb begin
    retire_cnt  = '0;
    retire_stop = 1'b0;
    retire_idx  = head_reg;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      retire_idx = head_reg + ROB_ID_WIDTH'(k);
      if (!retire_stop && occupied[retire_idx] && finished_reg[retire_idx] &&
          !exception_reg[retire_idx]) begin
        retire_cnt = retire_cnt + CW'(1);
      end else begin
        retire_stop = 1'b1;
      end
    end
    exc_at_head = occupied[head_reg] && finished_reg[head_reg] && exception_reg[head_reg];
  end

  always_comb begin
    state_next  = state_reg;
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    enable_next = 1'b0;
    flush_next  = 1'b0;
    num_next    = 2'd0;
    case (state_reg)
      NORMAL: begin
        head_next   = head_reg + retire_cnt[ROB_ID_WIDTH-1:0];
        if (alloc_fire) tail_next = tail_reg + ROB_ID_WIDTH'(alloc_cnt);
        count_next  = count_reg + (alloc_fire ? CW'(alloc_cnt) : CW'(0)) - retire_cnt;
        num_next    = retire_cnt[1:0];
        enable_next = (retire_cnt != '0);
        flush_next  = exc_at_head;
        if (exc_at_head) state_next = FLUSH;
      end
      FLUSH: begin
        head_next  = '0;
        tail_next  = '0;
        count_next = '0;
        state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg              <= NORMAL;
      head_reg               <= '0;
      tail_reg               <= '0;
      count_reg              <= '0;
      finished_reg           <= '0;
      exception_reg          <= '0;
      commit_feedback_enable <= 1'b0;
      commit_feedback_flush  <= 1'b0;
      commit_num             <= 2'd0;
      commit_rob_id          <= '0;
    end else begin
      state_reg              <= state_next;
      head_reg               <= head_next;
      tail_reg               <= tail_next;
      count_reg              <= count_next;
      finished_reg           <= finished_next;
      exception_reg          <= exception_next;
      commit_feedback_enable <= enable_next;
      commit_feedback_flush  <= flush_next;
      commit_num             <= num_next;
      commit_rob_id          <= head_reg;
    end
  end
endmodule

// File: doc/commit_retire.md
COMMIT_RETIRE -- requirements
Module: commit_retire

Interface
REQ-001 Parameters SHALL be ROB_DEPTH (default 16, power of two, reorder-buffer entries), ROB_ID_WIDTH (default 4, log2 ROB_DEPTH), WB_WIDTH (default 2, writeback channels in) and COMMIT_WIDTH (default 2, maximum retires per cycle).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 alloc_num  input  2  entries requested by rename this cycle (0..2); ignored while alloc_ready=0.
REQ-005 alloc_ready  output  1  free entries >= 2 and state NORMAL.
REQ-006 alloc_rob_id  output  ROB_ID_WIDTH  current tail; the second entry of a pair is tail+1 (mod ROB_DEPTH).
REQ-007 wb_commit_port_we  input  1  writeback bundle valid this cycle.
REQ-008 wb_commit_port_flush  input  1  writeback bundle squashed; when 1 the bundle is discarded.
REQ-009 wb_valid  input  WB_WIDTH  per-channel op finished.
REQ-010 wb_rob_id  input  WB_WIDTH x ROB_ID_WIDTH  per-channel ROB index.
REQ-011 wb_has_exception  input  WB_WIDTH  per-channel exception flag.
REQ-012 commit_feedback_enable  output  1  registered; at least one entry retired last cycle.
REQ-013 commit_feedback_flush  output  1  registered; pipeline flush pulse.
REQ-014 commit_num  output  2  registered; entries retired last cycle (0..COMMIT_WIDTH).
REQ-015 commit_rob_id  output  ROB_ID_WIDTH  registered; head index of the first entry retired last cycle.
REQ-016 rob_empty  output  1  combinational; occupancy count == 0.

Function
REQ-017 State per entry SHALL be finished and exception bits; global state SHALL be head, tail, count (ROB_ID_WIDTH+1 bits) and FSM {NORMAL, FLUSH}.
REQ-018 Allocation: if alloc_ready and alloc_num>0 -> clear finished/exception bits of the allocated entries, tail += alloc_num (mod ROB_DEPTH).
REQ-019 Writeback: if we=1, flush=0 and wb_valid[i]=1 -> set finished[wb_rob_id[i]] and exception[wb_rob_id[i]] = wb_has_exception[i]; channels are independent, and writeback to an unoccupied entry is ignored.
REQ-020 Retire (NORMAL): starting at head, count consecutive occupied, finished, non-exception entries, capped at COMMIT_WIDTH -> head and count advance by n, registered outputs show n the next cycle.
REQ-021 Writeback visibility: writeback and retire evaluate registered state only, so an entry written back in cycle t is retirable at the earliest in cycle t+1.
REQ-022 Exception: if the head entry is occupied, finished and has exception=1 -> retire 0 entries, set commit_feedback_flush=1 next cycle, FSM -> FLUSH.
REQ-023 Exception ordering: entries ahead of the exception entry retire normally in the same cycle, and flush is raised once the exception entry reaches head.
REQ-024 FLUSH lasts exactly one cycle: head=tail=count=0, all bits cleared, alloc_ready=0, writeback ignored, FSM -> NORMAL.
REQ-025 Simultaneous alloc/retire: count_next = count + alloc - retired; alloc_ready uses the current-cycle count only.
REQ-026 Wrap-around: head and tail are modulo ROB_DEPTH, and count distinguishes full (ROB_DEPTH) from empty (0).

Reset
REQ-027 On rst=0, asynchronously: head=tail=count=0, all bits=0, FSM=NORMAL, commit_feedback_enable=0, commit_feedback_flush=0, commit_num=0, commit_rob_id=0.
REQ-028 Reset value of the combinational outputs: rob_empty=1, alloc_ready=1, alloc_rob_id=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries with no flush pulse.

Verification
REQ-030 Reset release, alloc_num=2 then writeback ids 0,1 without exception -> the cycle after writeback, retire is computed; the following cycle, commit_num=2, commit_rob_id=0, commit_feedback_enable=1.
REQ-031 Out-of-order writeback: allocate ids 0..3, writeback id 2 then id 0 -> id 0 retires alone (commit_num=1); id 2 stays pending until id 1 is written back.
REQ-032 Exception at id 1 with ids 0..1 finished -> id 0 retires (commit_num=1), commit_feedback_flush=1 for exactly one cycle, then rob_empty=1 and alloc_rob_id=0.
REQ-033 Fill 16 entries -> alloc_ready=0 from count 15; retire 2 -> alloc_ready=1; tail wraps 15->0 correctly.
REQ-034 wb_commit_port_flush=1 with wb_valid=2'b11 -> no finished bits set, commit_num stays 0.
REQ-035 rst=0 asserted with 5 entries pending -> all outputs are at reset values immediately, without waiting for a clock edge.
